param_distram_fifo: RTL and testbench
=====================================

// Module: param_distram_fifo
// PURPOSE
// Parametrised first-word-fall-through (FWFT) FIFO built on distributed RAM, for isolation-layer buffering.
// Adds to the basic distRAM FIFO:
//  - optional registered output stage (breaks the distRAM read path)
//  - occupancy count output
//  - programmable almost-full / almost-empty flags
//  - sticky overflow / underflow error flags
// Sits between stream decouplers and bandwidth shapers.
// PARAMETERS
// DATA_WIDTH   8   payload width in bits
// ADDR_WIDTH   4   RAM address bits; RAM depth MEM_DEPTH = 2**ADDR_WIDTH
// REG_OUT      1   0: dout read combinationally from RAM; 1: dout driven from an output register
// AF_THRESH    MEM_DEPTH-2   almost_full asserted when count >= AF_THRESH
// AE_THRESH    2   almost_empty asserted when count <= AE_THRESH
// (derived) CAP = MEM_DEPTH + REG_OUT; CNT_W = $clog2(CAP+1)
// PORTS
// clk           in   1           single clock, all logic rising-edge
// rst           in   1           synchronous, active-high reset
// din           in   DATA_WIDTH  write data
// wr_en         in   1           write request
// full          out  1           RAM holds MEM_DEPTH entries
// dout          out  DATA_WIDTH  head-of-FIFO data (FWFT), valid while !empty
// rd_en         in   1           pop head entry
// empty         out  1           no entry visible at dout
// count         out  CNT_W       entries held (RAM plus output register)
// almost_full   out  1           count >= AF_THRESH
// almost_empty  out  1           count <= AE_THRESH
// overflow      out  1           sticky: wr_en seen while full
// underflow     out  1           sticky: rd_en seen while empty
// clr_err       in   1           clears overflow/underflow on the next edge
// BEHAVIOUR
// - Reset (rst=1 at clk edge) clears everything; it aborts any in-flight state:
//   - pointers, count and output-valid register go to 0
//   - empty=1, full=0, almost_empty=1, almost_full=0 (AF_THRESH>0), overflow=underflow=0
//   - dout is don't-care while empty
// - Accepted write: wr_acc = wr_en & !full.
//   - full blocks writes even if rd_en is high that cycle; no pass-through when full.
// - Accepted read: rd_acc = rd_en & !empty. rd_en while empty is ignored.
// - REG_OUT=0:
//   - dout = mem[rd_ptr]; empty = (mem_cnt==0)
//   - a write makes empty fall 1 cycle later
//   - simultaneous rd_acc & wr_acc leaves count unchanged and advances both pointers
// - REG_OUT=1:
//   - out_vld register holds the head entry; empty = !out_vld
//   - load the register from mem[rd_ptr] when mem_cnt>0 and (!out_vld or rd_acc); rd_ptr advances on that load
//   - a write into an empty FIFO makes empty fall 2 cycles after the write edge
//   - back-to-back reads sustain 1 pop/clk
// - Pointers are ADDR_WIDTH bits and wrap naturally from MEM_DEPTH-1 to 0.
// - mem_cnt is ADDR_WIDTH+1 bits; full = (mem_cnt == MEM_DEPTH).
// - count = mem_cnt + out_vld; it is registered, and the flags derived from it are combinational.
// - RAM write: synchronous on wr_acc; the read port is asynchronous (distRAM inference).
// - Errors: overflow is set on wr_en&full, underflow on rd_en&empty.
//   - both hold until clr_err or rst
//   - a set event in the same cycle as clr_err wins (flag stays 1)
// - Illegal parameter combinations are rejected with a $error at elaboration:
//   - AF_THRESH > CAP
//   - AE_THRESH >= CAP
// STRUCTURE
// - Package fifo_pkg: function cnt_width(depth) and localparams for the default thresholds.
// - One sub-module, fifo_out_reg: the REG_OUT prefetch register (valid/load/pop logic).
//   - instantiated under generate when REG_OUT=1; bypassed otherwise.
// - Top level holds the RAM array, pointers, mem_cnt, flags and error logic.
// TESTING
// - T1: reset, then write 0x11,0x22,0x33 on consecutive cycles, then read 3 times.
//   - dout sequence is 0x11,0x22,0x33; empty=1 after the third pop; count returns to 0.
// - T2: fill with 16 writes (ADDR_WIDTH=4, REG_OUT=0).
//   - full=1 and count=16 after the 16th write; almost_full rises at count=14.
//   - a 17th write is dropped and overflow=1.
// - T3: REG_OUT=1, single write to an empty FIFO at cycle N.
//   - empty=0 at cycle N+2; the FIFO accepts 17 entries before full with count=17.
// - T4: hold rd_en=wr_en=1 for 40 cycles at half occupancy.
//   - count stays constant, pointers wrap past 15, data order is preserved.
// - T5: rd_en while empty sets underflow=1.
//   - underflow holds across 5 idle cycles; clr_err clears it.
//   - clr_err together with a new rd_en-while-empty leaves underflow at 1.
// - T6: assert rst with 7 entries stored.
//   - next cycle: count=0, empty=1, overflow/underflow=0; the first subsequent write reads back correctly.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared helpers and default thresholds for the distributed-RAM FIFO family.
package fifo_pkg;

  localparam int DEF_AE_THRESH = 2;
  localparam int DEF_AF_MARGIN = 2;

  // Bits needed to hold any value 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_out_reg.sv
// Prefetch register that holds the FIFO head so dout comes from a flop
// instead of the asynchronous distRAM read path.
module fifo_out_reg #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] mem_data,
  input  logic                  mem_avail,
  input  logic                  pop,
  output logic                  load,
  output logic                  vld,
  output logic [DATA_WIDTH-1:0] data
);

  logic                  vld_reg;
  logic [DATA_WIDTH-1:0] data_reg;

  // Refill whenever the slot is free or is being emptied this cycle.
  assign load = mem_avail && (!vld_reg || pop);
  assign vld  = vld_reg;
  assign data = data_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_reg  <= 1'b0;
      data_reg <= '0;
    end else if (load) begin
      vld_reg  <= 1'b1;
      data_reg <= mem_data;
    end else if (pop) begin
      vld_reg  <= 1'b0;
    end
  end

endmodule

// File: rtl/param_distram_fifo.sv
// First-word-fall-through FIFO on distributed RAM with optional output
// register, occupancy count, almost flags and sticky error flags.
module param_distram_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int REG_OUT    = 1,
  parameter int AF_THRESH  = (2 ** ADDR_WIDTH) - DEF_AF_MARGIN,
  parameter int AE_THRESH  = DEF_AE_THRESH
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic [DATA_WIDTH-1:0]                            din,
  input  logic                                             wr_en,
  output logic                                             full,
  output logic [DATA_WIDTH-1:0]                            dout,
  input  logic                                             rd_en,
  output logic                                             empty,
  output logic [cnt_width((2 ** ADDR_WIDTH) + REG_OUT)-1:0] count,
  output logic                                             almost_full,
  output logic                                             almost_empty,
  output logic                                             overflow,
  output logic                                             underflow,
  input  logic                                             clr_err
);

  localparam int MEM_DEPTH = 2 ** ADDR_WIDTH;
  localparam int CAP       = MEM_DEPTH + REG_OUT;
  localparam int CNT_W     = cnt_width(CAP);

  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   MEM_ONE  = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH:0]   FULL_CNT = (ADDR_WIDTH + 1)'(MEM_DEPTH);
  localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]      AF_LVL   = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0]      AE_LVL   = CNT_W'(AE_THRESH);

  if (AF_THRESH > CAP) begin : g_bad_af
    $error("param_distram_fifo: AF_THRESH=%0d exceeds capacity %0d", AF_THRESH, CAP);
  end
  if (AE_THRESH >= CAP) begin : g_bad_ae
    $error("param_distram_fifo: AE_THRESH=%0d must be below capacity %0d", AE_THRESH, CAP);
  end

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] mem_head;
  logic [ADDR_WIDTH-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [ADDR_WIDTH:0]   mem_cnt_reg, mem_cnt_next;
  logic [CNT_W-1:0]      count_reg, count_next;
  logic                  overflow_reg, underflow_reg;
  logic                  wr_acc, rd_acc, mem_rd;

  assign full     = (mem_cnt_reg == FULL_CNT);
  assign wr_acc   = wr_en && !full;
  assign rd_acc   = rd_en && !empty;
  assign mem_head = mem[rd_ptr_reg];

  if (REG_OUT != 0) begin : g_out_reg
    logic out_vld;

    fifo_out_reg #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_out_reg (
      .clk       (clk),
      .rst       (rst),
      .mem_data  (mem_head),
      .mem_avail (mem_cnt_reg != '0),
      .pop       (rd_acc),
      .load      (mem_rd),
      .vld       (out_vld),
      .data      (dout)
    );

    assign empty = !out_vld;
  end else begin : g_no_out_reg
    assign mem_rd = rd_acc;
    assign dout   = mem_head;
    assign empty  = (mem_cnt_reg == '0);
  end

  // RAM occupancy moves on RAM-side reads; count follows user-visible pops.
  always_comb begin
    mem_cnt_next = mem_cnt_reg;
    if (wr_acc && !mem_rd) begin
      mem_cnt_next = mem_cnt_reg + MEM_ONE;
    end else if (!wr_acc && mem_rd) begin
      mem_cnt_next = mem_cnt_reg - MEM_ONE;
    end
  end

  always_comb begin
    count_next = count_reg;
    if (wr_acc && !rd_acc) begin
      count_next = count_reg + CNT_ONE;
    end else if (!wr_acc && rd_acc) begin
      count_next = count_reg - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      mem_cnt_reg   <= '0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (mem_rd) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
      mem_cnt_reg <= mem_cnt_next;
      count_reg   <= count_next;
      // A new error event outranks a simultaneous clear.
      if (wr_en && full) begin
        overflow_reg <= 1'b1;
      end else if (clr_err) begin
        overflow_reg <= 1'b0;
      end
      if (rd_en && empty) begin
        underflow_reg <= 1'b1;
      end else if (clr_err) begin
        underflow_reg <= 1'b0;
      end
    end
  end

  assign count        = count_reg;
  assign almost_full  = (count_reg >= AF_LVL);
  assign almost_empty = (count_reg <= AE_LVL);
  assign overflow     = overflow_reg;
  assign underflow    = underflow_reg;

endmodule

// File: tb/tb_param_distram_fifo.sv
// Drives a REG_OUT=0 and a REG_OUT=1 FIFO with the same stimulus and checks
// both against a queue-style reference model with per-entry write stamps.
module tb_param_distram_fifo;

  localparam int DEPTH = 16;
  localparam int AF    = 14;
  localparam int AE    = 2;

  logic       clk = 1'b0;
  logic       rst, wr_en, rd_en, clr_err;
  logic [7:0] din;

  logic       full0, empty0, af0, ae0, ovf0, unf0;
  logic [7:0] dout0;
  logic [4:0] count0;
  logic       full1, empty1, af1, ae1, ovf1, unf1;
  logic [7:0] dout1;
  logic [4:0] count1;

  always #5 clk = ~clk;

  param_distram_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .REG_OUT(0)) u_dut0 (
    .clk(clk), .rst(rst), .din(din), .wr_en(wr_en), .full(full0), .dout(dout0),
    .rd_en(rd_en), .empty(empty0), .count(count0), .almost_full(af0),
    .almost_empty(ae0), .overflow(ovf0), .underflow(unf0), .clr_err(clr_err)
  );

  param_distram_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .REG_OUT(1)) u_dut1 (
    .clk(clk), .rst(rst), .din(din), .wr_en(wr_en), .full(full1), .dout(dout1),
    .rd_en(rd_en), .empty(empty1), .count(count1), .almost_full(af1),
    .almost_empty(ae1), .overflow(ovf1), .underflow(unf1), .clr_err(clr_err)
  );

  // Reference model: index d is the REG_OUT value of the matching DUT.
  logic [7:0] m_data [2][64];
  int         m_wcyc [2][64];
  int         m_head [2];
  int         m_tail [2];
  bit         m_ovf  [2];
  bit         m_unf  [2];
  int         cyc;
  int         n_cmp;
  int         n_err;

  function automatic int m_size(input int d);
    return m_tail[d] - m_head[d];
  endfunction

  // The head becomes visible REG_OUT edges after the edge that wrote it.
  function automatic bit m_empty(input int d);
    if (m_size(d) == 0) return 1'b1;
    return (m_wcyc[d][m_head[d] % 64] + d) > cyc;
  endfunction

  // Full means the RAM itself holds DEPTH entries; a visible head in the
  // output register does not occupy RAM.
  function automatic bit m_full(input int d);
    int in_ram;
    in_ram = m_size(d) - ((d == 1 && !m_empty(d)) ? 1 : 0);
    return in_ram == DEPTH;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_dut(input int d, input logic f, input logic e, input logic a_f,
                           input logic a_e, input logic ov, input logic un,
                           input logic [7:0] dt, input logic [4:0] cn);
    int sz;
    bit me;
    sz = m_size(d);
    me = m_empty(d);
    chk($sformatf("d%0d_count", d), 32'(cn), sz);
    chk($sformatf("d%0d_empty", d), 32'(e), 32'(me));
    chk($sformatf("d%0d_full", d), 32'(f), 32'(m_full(d)));
    chk($sformatf("d%0d_almost_full", d), 32'(a_f), 32'(sz >= AF));
    chk($sformatf("d%0d_almost_empty", d), 32'(a_e), 32'(sz <= AE));
    chk($sformatf("d%0d_overflow", d), 32'(ov), 32'(m_ovf[d]));
    chk($sformatf("d%0d_underflow", d), 32'(un), 32'(m_unf[d]));
    if (!me) chk($sformatf("d%0d_dout", d), 32'(dt), 32'(m_data[d][m_head[d] % 64]));
  endtask

  task automatic step(input bit w, input logic [7:0] dv, input bit r, input bit c, input bit rs);
    bit wacc [2];
    bit racc [2];
    bit fpre [2];
    bit epre [2];
    rst = rs; wr_en = w; din = dv; rd_en = r; clr_err = c;
    for (int d = 0; d < 2; d++) begin
      fpre[d] = m_full(d);
      epre[d] = m_empty(d);
      wacc[d] = w && !fpre[d];
      racc[d] = r && !epre[d];
    end
    @(posedge clk);
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (rs) begin
        m_head[d] = 0; m_tail[d] = 0; m_ovf[d] = 1'b0; m_unf[d] = 1'b0;
      end else begin
        if (racc[d]) m_head[d]++;
        if (wacc[d]) begin
          m_data[d][m_tail[d] % 64] = dv;
          m_wcyc[d][m_tail[d] % 64] = cyc;
          m_tail[d]++;
        end
        if (w && fpre[d]) m_ovf[d] = 1'b1;
        else if (c)       m_ovf[d] = 1'b0;
        if (r && epre[d]) m_unf[d] = 1'b1;
        else if (c)       m_unf[d] = 1'b0;
      end
    end
    #1;
    check_dut(0, full0, empty0, af0, ae0, ovf0, unf0, dout0, count0);
    check_dut(1, full1, empty1, af1, ae1, ovf1, unf1, dout1, count1);
    $display("cyc=%0d rst=%b wr=%b rd=%b clr=%b din=%02h | c0=%0d e0=%b d0=%02h | c1=%0d e1=%b d1=%02h",
             cyc, rs, w, r, c, dv, count0, empty0, dout0, count1, empty1, dout1);
  endtask

  initial begin
    n_cmp = 0; n_err = 0; cyc = 0;
    for (int d = 0; d < 2; d++) begin
      m_head[d] = 0; m_tail[d] = 0; m_ovf[d] = 1'b0; m_unf[d] = 1'b0;
    end
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; din = '0;

    // Reset state
    step(0, 8'h00, 0, 0, 1);
    step(0, 8'h00, 0, 0, 1);
    chk("rst_empty0", 32'(empty0), 1);
    chk("rst_ae1", 32'(ae1), 1);

    // T1: three writes, three reads
    step(1, 8'h11, 0, 0, 0);
    step(1, 8'h22, 0, 0, 0);
    step(1, 8'h33, 0, 0, 0);
    chk("t1_head0", 32'(dout0), 32'h11);
    for (int i = 0; i < 3; i++) step(0, 8'h00, 1, 0, 0);
    chk("t1_empty_end0", 32'(empty0), 1);
    chk("t1_count_end1", 32'(count1), 0);

    // T2: fill past capacity on both variants
    for (int i = 1; i <= 18; i++) begin
      step(1, 8'(8'h40 + i), 0, 0, 0);
      if (i == 13) chk("t2_af_below0", 32'(af0), 0);
      if (i == 14) chk("t2_af_at0", 32'(af0), 1);
      if (i == 16) begin
        chk("t2_full16_0", 32'(full0), 1);
        chk("t2_count16_0", 32'(count0), 16);
      end
      if (i == 17) begin
        chk("t2_ovf17_0", 32'(ovf0), 1);
        chk("t2_count17_1", 32'(count1), 17);
      end
      if (i == 18) chk("t2_full18_1", 32'(full1), 1);
    end
    for (int i = 0; i < 20; i++) step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 0, 1, 0);

    // T3: single write into empty REG_OUT=1 FIFO
    step(1, 8'h5A, 0, 0, 0);
    chk("t3_empty_n1", 32'(empty1), 1);
    step(0, 8'h00, 0, 0, 0);
    chk("t3_empty_n2", 32'(empty1), 0);

    // T4: half occupancy, simultaneous read/write for 40 cycles
    for (int i = 0; i < 7; i++) step(1, 8'($urandom), 0, 0, 0);
    for (int i = 0; i < 40; i++) step(1, 8'($urandom), 1, 0, 0);
    chk("t4_count0", 32'(count0), 8);
    chk("t4_count1", 32'(count1), 8);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 99) < 55, 8'($urandom), $urandom_range(0, 99) < 50,
           $urandom_range(0, 99) < 5, $urandom_range(0, 199) == 0);
    end

    // T5: underflow stickiness and clear priority
    for (int i = 0; i < 20; i++) step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 0, 1, 0);
    step(0, 8'h00, 1, 0, 0);
    chk("t5_unf_set0", 32'(unf0), 1);
    for (int i = 0; i < 5; i++) begin
      step(0, 8'h00, 0, 0, 0);
      chk("t5_unf_hold1", 32'(unf1), 1);
    end
    step(0, 8'h00, 0, 1, 0);
    chk("t5_unf_clr0", 32'(unf0), 0);
    step(0, 8'h00, 1, 1, 0);
    chk("t5_unf_setwins0", 32'(unf0), 1);

    // T6: reset with seven entries stored
    for (int i = 0; i < 7; i++) step(1, 8'(8'h70 + i), 0, 0, 0);
    step(0, 8'h00, 0, 0, 1);
    chk("t6_count0", 32'(count0), 0);
    chk("t6_empty1", 32'(empty1), 1);
    chk("t6_unf0", 32'(unf0), 0);
    step(1, 8'hA5, 0, 0, 0);
    step(0, 8'h00, 0, 0, 0);
    chk("t6_dout0", 32'(dout0), 32'hA5);
    chk("t6_dout1", 32'(dout1), 32'hA5);
    step(0, 8'h00, 1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
